// File: rtl/mdu_unit.sv
// Multi-cycle multiply/divide unit for the EX stage: owns HI/LO, computes on accept,
// commits the latched result after a fixed latency and services mfhi/mflo/mthi/mtlo.
module mdu_unit #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [3:0]  MDUCtrl,
  input  logic        start,
  input  logic        req,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] out
);

  localparam int unsigned DW      = 32;
  localparam int unsigned MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;

  typedef enum logic {IDLE, BUSY} state_e;

  state_e            state_q, state_n;
  logic [CNT_W-1:0]  cnt_q, cnt_n;
  logic [DW-1:0]     thi_q, thi_n;
  logic [DW-1:0]     tlo_q, tlo_n;
  logic              dz_q, dz_n;
  logic [DW-1:0]     hi_q, hi_n;
  logic [DW-1:0]     lo_q, lo_n;

  logic signed [2*DW-1:0] a_sx, b_sx;
  logic [2*DW-1:0]        prod_s, prod_u;
  logic [DW-1:0]          div_u;
  logic signed [DW-1:0]   div_s;
  logic                   div_ovf;
  logic [DW-1:0]          q_u, r_u, q_s, r_s;
  logic                   is_md;

  // Arithmetic datapath; divisors are guarded so B==0 and MIN/-1 never reach the divider.
  always_comb begin
    a_sx    = {{DW{A[DW-1]}}, A};
    b_sx    = {{DW{B[DW-1]}}, B};
    prod_s  = a_sx * b_sx;
    prod_u  = {{DW{1'b0}}, A} * {{DW{1'b0}}, B};
    div_ovf = (A == 32'h8000_0000) && (B == 32'hFFFF_FFFF);
    div_u   = (B == '0) ? DW'(1) : B;
    div_s   = (div_ovf || (B == '0)) ? DW'(1) : $signed(B);
    q_u     = A / div_u;
    r_u     = A % div_u;
    q_s     = $signed(A) / div_s;
    r_s     = $signed(A) % div_s;
    is_md   = (MDUCtrl == OP_MULT) || (MDUCtrl == OP_MULTU) ||
              (MDUCtrl == OP_DIV)  || (MDUCtrl == OP_DIVU);
  end

  // State and architectural registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      thi_q   <= '0;
      tlo_q   <= '0;
      dz_q    <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
      thi_q   <= thi_n;
      tlo_q   <= tlo_n;
      dz_q    <= dz_n;
      hi_q    <= hi_n;
      lo_q    <= lo_n;
    end
  end

  // Next-state: accept / move-to in IDLE, countdown and commit in BUSY
  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q;
    thi_n   = thi_q;
    tlo_n   = tlo_q;
    dz_n    = dz_q;
    hi_n    = hi_q;
    lo_n    = lo_q;
    case (state_q)
      IDLE: begin
        if (!req) begin
          if (start && is_md) begin
            state_n = BUSY;
            dz_n    = 1'b0;
            case (MDUCtrl)
              OP_MULT: begin
                {thi_n, tlo_n} = prod_s;
                cnt_n          = CNT_W'(MULT_CYCLES);
              end
              OP_MULTU: begin
                {thi_n, tlo_n} = prod_u;
                cnt_n          = CNT_W'(MULT_CYCLES);
              end
              OP_DIV: begin
                thi_n = r_s;
                tlo_n = q_s;
                dz_n  = (B == '0);
                cnt_n = CNT_W'(DIV_CYCLES);
              end
              default: begin
                thi_n = r_u;
                tlo_n = q_u;
                dz_n  = (B == '0);
                cnt_n = CNT_W'(DIV_CYCLES);
              end
            endcase
          end else if (MDUCtrl == OP_MTHI) begin
            hi_n = A;
          end else if (MDUCtrl == OP_MTLO) begin
            lo_n = A;
          end
        end
      end
      BUSY: begin
        if (cnt_q == CNT_W'(1)) begin
          state_n = IDLE;
          cnt_n   = '0;
          if (!dz_q) begin
            hi_n = thi_q;
            lo_n = tlo_q;
          end
        end else begin
          cnt_n = cnt_q - CNT_W'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign busy = (state_q == BUSY);
  assign hi   = hi_q;
  assign lo   = lo_q;

  // Read port for mfhi/mflo, muxed with the ALU result downstream
  always_comb begin
    out = '0;
    if (MDUCtrl == OP_MFHI)      out = hi_q;
    else if (MDUCtrl == OP_MFLO) out = lo_q;
  end

endmodule

// File: tb/tb_mdu_unit.sv
// Self-checking bench for mdu_unit: fixed vectors, hand-written corner sequences,
// and random mult/div traffic checked against an arithmetic reference model.
module tb_mdu_unit;

  localparam int unsigned MULT_N = 5;
  localparam int unsigned DIV_N  = 10;

  localparam logic [3:0] C_NONE = 4'd0, C_MULT = 4'd1, C_MULTU = 4'd2, C_DIV = 4'd3,
                         C_DIVU = 4'd4, C_MFHI = 4'd5, C_MFLO = 4'd6, C_MTHI = 4'd7,
                         C_MTLO = 4'd8;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] A, B;
  logic [3:0]  MDUCtrl;
  logic        start, req;
  logic        busy;
  logic [31:0] hi, lo, out;

  int total = 0;
  int bad   = 0;
  logic [31:0] m_hi, m_lo;

  mdu_unit #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk(clk), .reset(reset), .A(A), .B(B), .MDUCtrl(MDUCtrl), .start(start),
    .req(req), .busy(busy), .hi(hi), .lo(lo), .out(out)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Reference arithmetic done in 64-bit integers straight from the operation definitions
  function automatic void model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] rhi, output logic [31:0] rlo, output bit upd);
    longint          sa, sb, sp, sq, sr;
    longint unsigned ua, ub, up, uq, ur;
    sa = $signed(a);
    sb = $signed(b);
    ua = a;
    ub = b;
    upd = 1'b1;
    rhi = 32'h0;
    rlo = 32'h0;
    case (op)
      C_MULT: begin
        sp = sa * sb;
        rhi = sp[63:32];
        rlo = sp[31:0];
      end
      C_MULTU: begin
        up = ua * ub;
        rhi = up[63:32];
        rlo = up[31:0];
      end
      C_DIV: begin
        if (b == 32'h0) upd = 1'b0;
        else begin
          sq = sa / sb;
          sr = sa % sb;
          rlo = sq[31:0];
          rhi = sr[31:0];
        end
      end
      default: begin
        if (b == 32'h0) upd = 1'b0;
        else begin
          uq = ua / ub;
          ur = ua % ub;
          rlo = uq[31:0];
          rhi = ur[31:0];
        end
      end
    endcase
  endfunction

  // Issue one mult/div, optionally raise req on busy cycle req_at, then check latency and result
  task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input int req_at);
    logic [31:0] ehi, elo;
    bit          upd;
    int          n;
    bit          early;
    int unsigned expc;
    model(op, a, b, ehi, elo, upd);
    expc = (op == C_MULT || op == C_MULTU) ? MULT_N : DIV_N;
    @(negedge clk);
    A = a; B = b; MDUCtrl = op; start = 1'b1; req = 1'b0;
    @(negedge clk);
    start = 1'b0; MDUCtrl = C_NONE; A = $urandom; B = $urandom;
    n = 0;
    early = 1'b0;
    while (busy && n < 200) begin
      if (hi !== m_hi || lo !== m_lo) early = 1'b1;
      n++;
      req = (n == req_at);
      @(negedge clk);
    end
    req = 1'b0;
    chk("busy_cycles", 32'(n), 32'(expc));
    chk("hold_while_busy", 32'(early), 32'd0);
    if (upd) begin
      m_hi = ehi;
      m_lo = elo;
    end
    chk("hi_after_op", hi, m_hi);
    chk("lo_after_op", lo, m_lo);
  endtask

  task automatic mt(input logic [3:0] op, input logic [31:0] val, input logic rq);
    @(negedge clk);
    MDUCtrl = op; A = val; req = rq;
    @(negedge clk);
    MDUCtrl = C_NONE; req = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (busy && n < 200) begin
      n++;
      @(negedge clk);
    end
    chk(name, 32'(busy), 32'd0);
  endtask

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a, b, ehi, elo;
  } vec_t;

  vec_t vt[8];

  initial begin
    vt[0] = '{C_MULT,  32'hFFFF_FFFE, 32'h3,          32'hFFFF_FFFF, 32'hFFFF_FFFA};
    vt[1] = '{C_MULTU, 32'hFFFF_FFFE, 32'h3,          32'h0000_0002, 32'hFFFF_FFFA};
    vt[2] = '{C_DIV,   32'hFFFF_FFF9, 32'h2,          32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vt[3] = '{C_DIVU,  32'h7,         32'h2,          32'h1,         32'h3};
    vt[4] = '{C_DIV,   32'h8000_0000, 32'hFFFF_FFFF,  32'h0,         32'h8000_0000};
    vt[5] = '{C_MULT,  32'h8000_0000, 32'h8000_0000,  32'h4000_0000, 32'h0};
    vt[6] = '{C_DIV,   32'h7,         32'hFFFF_FFFE,  32'h1,         32'hFFFF_FFFD};
    vt[7] = '{C_DIVU,  32'hFFFF_FFFF, 32'h10,         32'hF,         32'h0FFF_FFFF};

    reset = 1'b1; A = '0; B = '0; MDUCtrl = C_NONE; start = 1'b0; req = 1'b0;
    m_hi = '0; m_lo = '0;
    repeat (2) @(negedge clk);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_hi", hi, 32'h0);
    chk("reset_lo", lo, 32'h0);
    chk("reset_out", out, 32'h0);
    reset = 1'b0;

    for (int i = 0; i < 8; i++) begin
      do_op(vt[i].op, vt[i].a, vt[i].b, -1);
      chk($sformatf("vec%0d_hi", i), hi, vt[i].ehi);
      chk($sformatf("vec%0d_lo", i), lo, vt[i].elo);
    end

    // Divide by zero keeps HI/LO
    mt(C_MTHI, 32'h11, 1'b0); m_hi = 32'h11;
    mt(C_MTLO, 32'h22, 1'b0); m_lo = 32'h22;
    chk("mthi_hi", hi, 32'h11);
    chk("mtlo_lo", lo, 32'h22);
    do_op(C_DIV, 32'h1234, 32'h0, -1);
    chk("divz_hi", hi, 32'h11);
    chk("divz_lo", lo, 32'h22);
    do_op(C_DIVU, 32'hFFFF_0000, 32'h0, -1);
    chk("divuz_lo", lo, 32'h22);

    // Move-to and read port
    mt(C_MTHI, 32'hABCD, 1'b0); m_hi = 32'hABCD;
    chk("mthi_abcd", hi, 32'hABCD);
    MDUCtrl = C_MFHI; #1;
    chk("out_mfhi", out, 32'hABCD);
    MDUCtrl = C_MFLO; #1;
    chk("out_mflo", out, 32'h22);
    MDUCtrl = C_MTHI; #1;
    chk("out_other", out, 32'h0);
    MDUCtrl = C_NONE;

    // MTLO/MTHI while busy are dropped; the MULT still lands
    @(negedge clk);
    A = 32'd5; B = 32'd6; MDUCtrl = C_MULT; start = 1'b1;
    @(negedge clk);
    start = 1'b0; MDUCtrl = C_MTLO; A = 32'hDEAD;
    @(negedge clk);
    MDUCtrl = C_MTHI; A = 32'hBEEF;
    @(negedge clk);
    MDUCtrl = C_NONE;
    wait_idle("busy_mt_timeout");
    m_hi = 32'h0; m_lo = 32'd30;
    chk("mt_busy_hi", hi, 32'h0);
    chk("mt_busy_lo", lo, 32'd30);

    // req blocks start and move-to
    @(negedge clk);
    A = 32'd9; B = 32'd9; MDUCtrl = C_MULT; start = 1'b1; req = 1'b1;
    @(negedge clk);
    start = 1'b0; req = 1'b0; MDUCtrl = C_NONE;
    chk("req_start_busy", 32'(busy), 32'd0);
    chk("req_start_lo", lo, m_lo);
    mt(C_MTLO, 32'h5555, 1'b1);
    chk("req_mtlo_lo", lo, m_lo);
    mt(C_MTHI, 32'h6666, 1'b1);
    chk("req_mthi_hi", hi, m_hi);

    // req during an in-flight op does not abort it
    do_op(C_MULT, 32'hFFFF_FFF0, 32'h1000, 2);
    do_op(C_DIV, 32'hFFFF_FF00, 32'h7, 5);

    // Asynchronous reset mid-divide
    @(negedge clk);
    A = 32'd100; B = 32'd7; MDUCtrl = C_DIV; start = 1'b1;
    @(negedge clk);
    start = 1'b0; MDUCtrl = C_NONE;
    repeat (3) @(negedge clk);
    chk("pre_reset_busy", 32'(busy), 32'd1);
    #1 reset = 1'b1;
    #1;
    chk("async_busy", 32'(busy), 32'd0);
    chk("async_hi", hi, 32'h0);
    chk("async_lo", lo, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    repeat (15) @(negedge clk);
    chk("post_reset_busy", 32'(busy), 32'd0);
    chk("post_reset_hi", hi, 32'h0);
    chk("post_reset_lo", lo, 32'h0);
    m_hi = '0; m_lo = '0;

    // Random traffic
    for (int i = 0; i < 40; i++) begin
      logic [3:0]  op;
      logic [31:0] a, b;
      op = 4'($urandom_range(1, 4));
      a  = $urandom;
      case ($urandom_range(0, 7))
        0:       b = 32'h0;
        1:       b = 32'($urandom_range(1, 15));
        2:       b = 32'hFFFF_FFFF;
        default: b = $urandom;
      endcase
      do_op(op, a, b, ($urandom_range(0, 3) == 0) ? 1 : -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
